jzjpcc_decode_stage: RTL and testbench

// - Parametrised decode stage of the jzjpcc RV32I/RV32E pipeline, sitting between fetch and execute.
// - Classifies the opcode and forms the I/S/B/U/J immediate. Detects illegal encodings.
// - Owns the decode->execute pipeline register, which supports valid, stall and flush.
// - Detects load-use hazards and inserts a single bubble for each one.

---
 rtl/jzjpcc_decode_stage.sv | 158 +++++++++++++++
 tb/tb_jzjpcc_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_decode_stage.sv
// jzjpcc_decode_stage
//   Decode stage of the jzjpcc RV32I/RV32E pipeline. Classifies the opcode,
//   builds the sign-extended immediate, flags illegal encodings, owns the
//   decode->execute pipeline register and inserts one bubble per load-use hazard.
// Ports
//   clock, reset (async, active-low)           clocking / reset
//   instruction_decode, currentPC_decode,      instruction from fetch ([1:0] implied 2'b11)
//   valid_decode, stall_decode, flush_decode   qualifiers and pipeline control
//   rs1Addr_decode, rs2Addr_decode             combinational register-file read addresses
//   hazardStall_fetch                          combinational; fetch holds PC/instruction
//   *_execute                                  registered decode results for execute
module jzjpcc_decode_stage #(
  parameter int unsigned PC_MAX_B           = 15,
  parameter int unsigned NUM_REGS           = 32,
  parameter bit          LOAD_USE_INTERLOCK = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:2]         instruction_decode,
  input  logic [PC_MAX_B:2]   currentPC_decode,
  input  logic                valid_decode,
  input  logic                stall_decode,
  input  logic                flush_decode,
  output logic [4:0]          rs1Addr_decode,
  output logic [4:0]          rs2Addr_decode,
  output logic                hazardStall_fetch,
  output logic                valid_execute,
  output logic [PC_MAX_B:2]   currentPC_execute,
  output logic [31:0]         immediate_execute,
  output logic [6:2]          opcode_execute,
  output logic [2:0]          funct3_execute,
  output logic                funct7b5_execute,
  output logic [4:0]          rdAddr_execute,
  output logic [4:0]          rs1Addr_execute,
  output logic [4:0]          rs2Addr_execute,
  output logic                isLoad_execute,
  output logic                illegal_execute
);

  localparam bit RV32E = (NUM_REGS == 16);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  logic [31:2] ins;
  logic [6:2]  opcode;
  logic [4:0]  rd_addr;
  fmt_e        fmt;
  logic        rs1_read;
  logic        rs2_read;
  logic        is_load;
  logic [31:0] imm;
  logic        uses_rd;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        reg_illegal;
  logic        illegal;
  logic        hazard;

  assign ins            = instruction_decode;
  assign opcode         = ins[6:2];
  assign rd_addr        = ins[11:7];
  assign rs1Addr_decode = ins[19:15];
  assign rs2Addr_decode = ins[24:20];

  // Opcode classification; rs1_read/rs2_read mark true operand reads for the interlock
  always_comb begin
    fmt      = FMT_BAD;
    rs1_read = 1'b0;
    rs2_read = 1'b0;
    is_load  = 1'b0;
    case (opcode)
      5'b01101, 5'b00101: fmt = FMT_U;
      5'b11011:           fmt = FMT_J;
      5'b11001: begin fmt = FMT_I; rs1_read = 1'b1; end
      5'b00000: begin fmt = FMT_I; rs1_read = 1'b1; is_load = 1'b1; end
      5'b00100: begin fmt = FMT_I; rs1_read = 1'b1; end
      5'b00011, 5'b11100: fmt = FMT_I;
      5'b11000: begin fmt = FMT_B; rs1_read = 1'b1; rs2_read = 1'b1; end
      5'b01000: begin fmt = FMT_S; rs1_read = 1'b1; rs2_read = 1'b1; end
      5'b01100: begin fmt = FMT_R; rs1_read = 1'b1; rs2_read = 1'b1; end
      default:  fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{21{ins[31]}}, ins[30:20]};
      FMT_S:   imm = {{21{ins[31]}}, ins[30:25], ins[11:7]};
      FMT_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {ins[31:12], 12'h000};
      FMT_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // RV32E legality looks only at the register fields the format encodes
  // (e.g. SYSTEM/MISC-MEM still carry rd/rs1 fields even though they are not interlocked)
  assign uses_rd     = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  assign uses_rs1    = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign uses_rs2    = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign reg_illegal = RV32E && ((uses_rd  && rd_addr[4]) ||
                                 (uses_rs1 && rs1Addr_decode[4]) ||
                                 (uses_rs2 && rs2Addr_decode[4]));
  assign illegal     = (fmt == FMT_BAD) || reg_illegal;

  // A bubble leaves the load in the execute fields but clears valid_execute,
  // so the re-presented consumer sees no hazard on the following cycle.
  assign hazard = LOAD_USE_INTERLOCK && valid_execute && isLoad_execute && valid_decode &&
                  (rdAddr_execute != '0) &&
                  ((rs1_read && (rs1Addr_decode == rdAddr_execute)) ||
                   (rs2_read && (rs2Addr_decode == rdAddr_execute)));

  assign hazardStall_fetch = hazard && !flush_decode && !stall_decode;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_execute     <= 1'b0;
      currentPC_execute <= '0;
      immediate_execute <= '0;
      opcode_execute    <= '0;
      funct3_execute    <= '0;
      funct7b5_execute  <= 1'b0;
      rdAddr_execute    <= '0;
      rs1Addr_execute   <= '0;
      rs2Addr_execute   <= '0;
      isLoad_execute    <= 1'b0;
      illegal_execute   <= 1'b0;
    end else if (flush_decode) begin
      valid_execute <= 1'b0;
    end else if (!stall_decode) begin
      if (hazard) begin
        valid_execute <= 1'b0;
      end else begin
        valid_execute     <= valid_decode;
        currentPC_execute <= currentPC_decode;
        immediate_execute <= imm;
        opcode_execute    <= opcode;
        funct3_execute    <= ins[14:12];
        funct7b5_execute  <= ins[30];
        rdAddr_execute    <= rd_addr;
        rs1Addr_execute   <= rs1Addr_decode;
        rs2Addr_execute   <= rs2Addr_decode;
        isLoad_execute    <= is_load;
        illegal_execute   <= illegal && valid_decode;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_decode_stage.sv
// tb_jzjpcc_decode_stage
//   Scoreboard bench for jzjpcc_decode_stage. Three instances share stimulus:
//   default RV32I with interlock, RV32E (NUM_REGS=16), and interlock disabled.
module tb_jzjpcc_decode_stage;

  localparam logic [31:0] ADDI   = 32'hFFB10093; // addi x1,x2,-5
  localparam logic [31:0] LUI    = 32'hABCDE1B7; // lui x3,0xABCDE
  localparam logic [31:0] BEQ    = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] JAL    = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] LW5    = 32'h00032283; // lw x5,0(x6)
  localparam logic [31:0] ADD7   = 32'h008283B3; // add x7,x5,x8
  localparam logic [31:0] LW6    = 32'h0002A303; // lw x6,0(x5)
  localparam logic [31:0] ADDX6  = 32'h008303B3; // add x7,x6,x8
  localparam logic [31:0] LW0    = 32'h00032003; // lw x0,0(x6)
  localparam logic [31:0] ADDX0  = 32'h008003B3; // add x7,x0,x8
  localparam logic [31:0] BADOP  = 32'h0000007F; // opcode 11111
  localparam logic [31:0] ADD17  = 32'h002088B3; // add x17,x1,x2

  logic        clock = 1'b0;
  logic        reset;
  logic [31:2] instruction_decode;
  logic [15:2] currentPC_decode;
  logic        valid_decode, stall_decode, flush_decode;

  logic [4:0]  rs1Addr_decode, rs2Addr_decode;
  logic        hazardStall_fetch, valid_execute, funct7b5_execute, isLoad_execute, illegal_execute;
  logic [15:2] currentPC_execute;
  logic [31:0] immediate_execute;
  logic [4:0]  opcode_execute, rdAddr_execute, rs1Addr_execute, rs2Addr_execute;
  logic [2:0]  funct3_execute;

  logic [4:0]  e_rs1d, e_rs2d, e_opc, e_rd, e_rs1, e_rs2;
  logic        e_haz, e_valid, e_f7, e_ld, e_ill;
  logic [15:2] e_pc;
  logic [31:0] e_imm;
  logic [2:0]  e_f3;

  logic [4:0]  n_rs1d, n_rs2d, n_opc, n_rd, n_rs1, n_rs2;
  logic        n_haz, n_valid, n_f7, n_ld, n_ill;
  logic [15:2] n_pc;
  logic [31:0] n_imm;
  logic [2:0]  n_f3;

  jzjpcc_decode_stage dut (
    .clock(clock), .reset(reset), .instruction_decode(instruction_decode),
    .currentPC_decode(currentPC_decode), .valid_decode(valid_decode),
    .stall_decode(stall_decode), .flush_decode(flush_decode),
    .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
    .hazardStall_fetch(hazardStall_fetch), .valid_execute(valid_execute),
    .currentPC_execute(currentPC_execute), .immediate_execute(immediate_execute),
    .opcode_execute(opcode_execute), .funct3_execute(funct3_execute),
    .funct7b5_execute(funct7b5_execute), .rdAddr_execute(rdAddr_execute),
    .rs1Addr_execute(rs1Addr_execute), .rs2Addr_execute(rs2Addr_execute),
    .isLoad_execute(isLoad_execute), .illegal_execute(illegal_execute)
  );

  jzjpcc_decode_stage #(.NUM_REGS(16)) dut_e (
    .clock(clock), .reset(reset), .instruction_decode(instruction_decode),
    .currentPC_decode(currentPC_decode), .valid_decode(valid_decode),
    .stall_decode(stall_decode), .flush_decode(flush_decode),
    .rs1Addr_decode(e_rs1d), .rs2Addr_decode(e_rs2d),
    .hazardStall_fetch(e_haz), .valid_execute(e_valid),
    .currentPC_execute(e_pc), .immediate_execute(e_imm),
    .opcode_execute(e_opc), .funct3_execute(e_f3),
    .funct7b5_execute(e_f7), .rdAddr_execute(e_rd),
    .rs1Addr_execute(e_rs1), .rs2Addr_execute(e_rs2),
    .isLoad_execute(e_ld), .illegal_execute(e_ill)
  );

  jzjpcc_decode_stage #(.LOAD_USE_INTERLOCK(1'b0)) dut_n (
    .clock(clock), .reset(reset), .instruction_decode(instruction_decode),
    .currentPC_decode(currentPC_decode), .valid_decode(valid_decode),
    .stall_decode(stall_decode), .flush_decode(flush_decode),
    .rs1Addr_decode(n_rs1d), .rs2Addr_decode(n_rs2d),
    .hazardStall_fetch(n_haz), .valid_execute(n_valid),
    .currentPC_execute(n_pc), .immediate_execute(n_imm),
    .opcode_execute(n_opc), .funct3_execute(n_f3),
    .funct7b5_execute(n_f7), .rdAddr_execute(n_rd),
    .rs1Addr_execute(n_rs1), .rs2Addr_execute(n_rs2),
    .isLoad_execute(n_ld), .illegal_execute(n_ill)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [15:2] pc;
    logic [31:0] imm;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic        ld, ill;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last;
  logic [15:2] pc_cnt;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic v, input logic [31:0] imm,
                              input logic ld, input logic ill);
    exp_t e;
    e.v = v; e.pc = pc_cnt; e.imm = imm; e.opc = ins[6:2]; e.f3 = ins[14:12];
    e.f7 = ins[30]; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.ld = ld; e.ill = ill;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    pc_cnt             = pc_cnt + 14'd1;
    currentPC_decode   = pc_cnt;
    instruction_decode = ins[31:2];
    valid_decode       = v;
    stall_decode       = st;
    flush_decode       = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check_val({tag, ".sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({tag, ".valid"}, valid_execute, e.v);
      check_val({tag, ".pc"}, currentPC_execute, e.pc);
      check_val({tag, ".imm"}, immediate_execute, e.imm);
      check_val({tag, ".opcode"}, opcode_execute, e.opc);
      check_val({tag, ".funct3"}, funct3_execute, e.f3);
      check_val({tag, ".f7b5"}, funct7b5_execute, e.f7);
      check_val({tag, ".rd"}, rdAddr_execute, e.rd);
      check_val({tag, ".rs1"}, rs1Addr_execute, e.rs1);
      check_val({tag, ".rs2"}, rs2Addr_execute, e.rs2);
      check_val({tag, ".isload"}, isLoad_execute, e.ld);
      check_val({tag, ".illegal"}, illegal_execute, e.ill);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".valid"}, valid_execute, 0);
    check_val({tag, ".pc"}, currentPC_execute, 0);
    check_val({tag, ".imm"}, immediate_execute, 0);
    check_val({tag, ".opcode"}, opcode_execute, 0);
    check_val({tag, ".funct3"}, funct3_execute, 0);
    check_val({tag, ".f7b5"}, funct7b5_execute, 0);
    check_val({tag, ".rd"}, rdAddr_execute, 0);
    check_val({tag, ".rs1"}, rs1Addr_execute, 0);
    check_val({tag, ".rs2"}, rs2Addr_execute, 0);
    check_val({tag, ".isload"}, isLoad_execute, 0);
    check_val({tag, ".illegal"}, illegal_execute, 0);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] imm, input logic ld,
                       input logic ill, input string tag);
    drive(ins, 1'b1, 1'b0, 1'b0);
    last = mk(ins, 1'b1, imm, ld, ill);
    sb_q.push_back(last);
    step();
    pop_check(tag);
  endtask

  // Consumer of the load currently in execute: one bubble, then issue.
  task automatic load_use(input logic [31:0] ins, input logic ld, input string tag);
    exp_t b;
    drive(ins, 1'b1, 1'b0, 1'b0);
    #1;
    check_val({tag, ".haz_on"}, hazardStall_fetch, 1);
    check_val({tag, ".noil_haz"}, n_haz, 0);
    b = last;
    b.v = 1'b0;
    sb_q.push_back(b);
    step();
    pop_check({tag, ".bubble"});
    check_val({tag, ".haz_clear"}, hazardStall_fetch, 0);
    check_val({tag, ".noil_valid"}, n_valid, 1);
    check_val({tag, ".noil_rs1"}, n_rs1, ins[19:15]);
    last = mk(ins, 1'b1, 32'h0, ld, 1'b0);
    sb_q.push_back(last);
    step();
    pop_check({tag, ".issue"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t h;
    reset = 1'b0;
    pc_cnt = '0;
    instruction_decode = '0;
    currentPC_decode = '0;
    valid_decode = 1'b0;
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    repeat (2) step();
    check_zero("rst");
    reset = 1'b1;

    issue(ADDI, 32'hFFFFFFFB, 1'b0, 1'b0, "addi");
    issue(LUI,  32'hABCDE000, 1'b0, 1'b0, "lui");
    // U format does not use the rs1/rs2 fields, whose bit 4 is set here
    check_val("rv32e.lui_legal", e_ill, 0);
    issue(BEQ,  32'hFFFFFFFC, 1'b0, 1'b0, "beq");
    issue(JAL,  32'h00000800, 1'b0, 1'b0, "jal");

    issue(LW5, 32'h0, 1'b1, 1'b0, "lw5");
    load_use(ADD7, 1'b0, "add7");
    issue(LW5, 32'h0, 1'b1, 1'b0, "lw5b");
    load_use(LW6, 1'b1, "lw6");
    load_use(ADDX6, 1'b0, "addx6");

    issue(LW0, 32'h0, 1'b1, 1'b0, "lw0");
    drive(ADDX0, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("x0.haz_off", hazardStall_fetch, 0);
    last = mk(ADDX0, 1'b1, 32'h0, 1'b0, 1'b0);
    sb_q.push_back(last);
    step();
    pop_check("addx0");

    issue(ADDI, 32'hFFFFFFFB, 1'b0, 1'b0, "addi2");
    for (int unsigned i = 0; i < 3; i++) begin
      drive(LUI, 1'b1, 1'b1, 1'b0);
      sb_q.push_back(last);
      step();
      pop_check($sformatf("stall%0d", i));
    end
    drive(LUI, 1'b1, 1'b1, 1'b1);
    h = last;
    h.v = 1'b0;
    sb_q.push_back(h);
    step();
    pop_check("flush_stall");
    drive(LUI, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(h);
    step();
    pop_check("flush_held");
    drive(JAL, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(mk(JAL, 1'b0, 32'h00000800, 1'b0, 1'b0));
    step();
    pop_check("stall_release");

    issue(BADOP, 32'h0, 1'b0, 1'b1, "badop");
    drive(BADOP, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(mk(BADOP, 1'b0, 32'h0, 1'b0, 1'b0));
    step();
    pop_check("badop_invalid");
    issue(ADD17, 32'h0, 1'b0, 1'b0, "add17");
    check_val("rv32e.add17_valid", e_valid, 1);
    check_val("rv32e.add17_illegal", e_ill, 1);

    issue(ADDI, 32'hFFFFFFFB, 1'b0, 1'b0, "addi3");
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    step();
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
